// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback/drain bundle between the issue stage and the hazard scoreboard.
// The master drives decode and writeback; the slave reports issue, stall and status.
interface hazard_scoreboard_if #(parameter int NREG = 16);
  logic            dec_valid;
  logic [3:0]      dec_rd;
  logic            dec_wr;
  logic [3:0]      dec_rs1;
  logic [3:0]      dec_rs2;
  logic            dec_rs1_used;
  logic            dec_rs2_used;
  logic            flush;
  logic            wb_en;
  logic [3:0]      wb_rd;
  logic            drain_req;
  logic            issue;
  logic            stall;
  logic            drained;
  logic [NREG-1:0] pending;
  logic            deadlock;
  logic [15:0]     stall_cycles;

  modport master (
    output dec_valid, dec_rd, dec_wr, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           flush, wb_en, wb_rd, drain_req,
    input  issue, stall, drained, pending, deadlock, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_rd, dec_wr, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           flush, wb_en, wb_rd, drain_req,
    output issue, stall, drained, pending, deadlock, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight writes, stalls RAW/WAW hazards,
// supports quiesce (drain) and flags stalls that never resolve.
module hazard_scoreboard #(
  parameter int NREG    = 16,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  hazard_scoreboard_if.slave bus
);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [NREG-1:0] pend_q, pend_nxt, wb_mask, eff;
  logic            hazard, issue, stall, drained;
  logic [6:0]      scnt;
  logic            dl_q;
  logic [15:0]     sc_q;

  always_comb begin
    wb_mask = '0;
    if (bus.wb_en) wb_mask[bus.wb_rd] = 1'b1;
  end

  // Writeback this cycle is forwarded, so it no longer blocks readers.
  assign eff    = pend_q & ~wb_mask;
  assign hazard = (bus.dec_rs1_used & eff[bus.dec_rs1]) |
                  (bus.dec_rs2_used & eff[bus.dec_rs2]) |
                  (bus.dec_wr       & eff[bus.dec_rd]);

  always_comb begin
    issue     = 1'b0;
    stall     = 1'b0;
    drained   = 1'b0;
    state_nxt = state;
    if (!reset) begin
      case (state)
        S_RUN, S_STALL: begin
          issue = bus.dec_valid & ~hazard & ~bus.flush;
          stall = bus.dec_valid &  hazard & ~bus.flush;
        end
        S_DRAIN: begin
          stall   = bus.dec_valid & ~bus.flush;
          drained = (eff == '0);
        end
        default: ;
      endcase
    end
    case (state)
      S_RUN:   if (stall) state_nxt = S_STALL;
               else if (bus.drain_req) state_nxt = S_DRAIN;
      S_STALL: if (!hazard || bus.flush) state_nxt = S_RUN;
      S_DRAIN: if (!bus.drain_req) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // Clear first, then set: an issue to the register being written back keeps it pending.
  always_comb begin
    pend_nxt = pend_q & ~wb_mask;
    if (issue && bus.dec_wr) pend_nxt[bus.dec_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_RUN;
      pend_q <= '0;
      scnt   <= '0;
      dl_q   <= 1'b0;
      sc_q   <= '0;
    end else begin
      state  <= state_nxt;
      pend_q <= pend_nxt;
      if (stall) begin
        if (scnt != '1) scnt <= scnt + 7'd1;
        if (({1'b0, scnt} + 8'd1) >= 8'(TIMEOUT)) dl_q <= 1'b1;
        if (sc_q != '1) sc_q <= sc_q + 16'd1;
      end else begin
        scnt <= '0;
      end
    end
  end

  assign bus.issue        = issue;
  assign bus.stall        = stall;
  assign bus.drained      = drained;
  assign bus.pending      = pend_q;
  assign bus.deadlock     = dl_q;
  assign bus.stall_cycles = sc_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: RAW, WAW, same-cycle set/clear, flush,
// drain, reset mid-drain and stall timeout.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  typedef struct packed { logic issue; logic stall; logic drained; } exp_t;
  exp_t q[$];

  hazard_scoreboard_if #(.NREG(16)) bus();
  hazard_scoreboard #(.NREG(16), .TIMEOUT(64)) dut (.clk(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, queue expected combinational outputs, compare shortly after.
  task automatic cyc(input string tag, input logic r, input logic v, input logic [3:0] rd,
                     input logic wr, input logic [3:0] r1, input logic u1, input logic [3:0] r2,
                     input logic u2, input logic fl, input logic we, input logic [3:0] wrd,
                     input logic dr, input logic ei, input logic es, input logic ed);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.dec_valid = v;  bus.dec_rd = rd;  bus.dec_wr = wr;
    bus.dec_rs1 = r1;   bus.dec_rs1_used = u1;
    bus.dec_rs2 = r2;   bus.dec_rs2_used = u2;
    bus.flush = fl;     bus.wb_en = we;   bus.wb_rd = wrd;  bus.drain_req = dr;
    q.push_back('{issue: ei, stall: es, drained: ed});
    #1;
    e = q.pop_front();
    chk({tag, ".issue"},   32'(bus.issue),   32'(e.issue));
    chk({tag, ".stall"},   32'(bus.stall),   32'(e.stall));
    chk({tag, ".drained"}, 32'(bus.drained), 32'(e.drained));
  endtask

  initial begin
    // reset holds issue/stall low regardless of inputs
    cyc("rst_a", 1, 1,1,1, 0,0,0,0, 0, 0,0, 0, 0,0,0);
    chk("rst_a.pending", 32'(bus.pending), 32'h0);
    chk("rst_a.deadlock", 32'(bus.deadlock), 32'h0);
    chk("rst_a.stall_cycles", 32'(bus.stall_cycles), 32'h0);
    cyc("rst_b", 1, 1,1,1, 1,1,0,0, 0, 0,0, 1, 0,0,0);

    // RAW on r5
    cyc("raw_iss", 0, 1,5,1, 0,0,0,0, 0, 0,0, 0, 1,0,0);
    chk("raw_iss.pending", 32'(bus.pending), 32'h0);
    cyc("raw_st1", 0, 1,0,0, 5,1,0,0, 0, 0,0, 0, 0,1,0);
    chk("raw_st1.pending", 32'(bus.pending), 32'h0020);
    cyc("raw_st2", 0, 1,0,0, 5,1,0,0, 0, 0,0, 0, 0,1,0);
    cyc("raw_st3", 0, 1,0,0, 5,1,0,0, 0, 0,0, 0, 0,1,0);
    cyc("raw_wb",  0, 1,0,0, 5,1,0,0, 0, 1,5, 0, 1,0,0);
    chk("raw_wb.stall_cycles", 32'(bus.stall_cycles), 32'd3);
    cyc("nop1",    0, 0,0,0, 0,0,0,0, 0, 0,0, 0, 0,0,0);
    chk("nop1.pending", 32'(bus.pending), 32'h0);

    // same-cycle set and clear on r3
    cyc("sc_iss",  0, 1,3,1, 0,0,0,0, 0, 0,0, 0, 1,0,0);
    cyc("sc_both", 0, 1,3,1, 0,0,0,0, 0, 1,3, 0, 1,0,0);
    cyc("nop_wb3", 0, 0,0,0, 0,0,0,0, 0, 1,3, 0, 0,0,0);
    chk("sc_both.pending", 32'(bus.pending), 32'h0008);
    cyc("wb_idle", 0, 0,0,0, 0,0,0,0, 0, 1,6, 0, 0,0,0);
    chk("nop_wb3.pending", 32'(bus.pending), 32'h0);

    // WAW on r7; writeback of a non-pending register is ignored
    cyc("waw_iss", 0, 1,7,1, 0,0,0,0, 0, 0,0, 0, 1,0,0);
    chk("wb_idle.pending", 32'(bus.pending), 32'h0);
    cyc("waw_st1", 0, 1,7,1, 0,0,0,0, 0, 0,0, 0, 0,1,0);
    chk("waw_st1.pending", 32'(bus.pending), 32'h0080);
    cyc("waw_st2", 0, 1,7,1, 0,0,0,0, 0, 0,0, 0, 0,1,0);
    cyc("waw_wb",  0, 1,7,1, 0,0,0,0, 0, 1,7, 0, 1,0,0);
    cyc("nop_wb7", 0, 0,0,0, 0,0,0,0, 0, 1,7, 0, 0,0,0);
    chk("waw_wb.pending", 32'(bus.pending), 32'h0080);
    chk("waw_wb.stall_cycles", 32'(bus.stall_cycles), 32'd5);

    // flush during STALL returns to RUN, then drain is accepted immediately
    cyc("fl_iss",  0, 1,4,1, 0,0,0,0, 0, 0,0, 0, 1,0,0);
    chk("nop_wb7.pending", 32'(bus.pending), 32'h0);
    cyc("fl_st",   0, 1,0,0, 0,0,4,1, 0, 0,0, 0, 0,1,0);
    cyc("fl_fl",   0, 1,8,1, 0,0,4,1, 1, 0,0, 0, 0,0,0);
    cyc("fl_drq",  0, 0,0,0, 0,0,0,0, 0, 0,0, 1, 0,0,0);
    chk("fl_fl.pending", 32'(bus.pending), 32'h0010);
    cyc("fl_drn",  0, 1,0,0, 0,0,0,0, 0, 0,0, 1, 0,1,0);
    cyc("fl_dwb",  0, 0,0,0, 0,0,0,0, 0, 1,4, 1, 0,0,1);
    cyc("fl_dlo",  0, 0,0,0, 0,0,0,0, 0, 0,0, 0, 0,0,1);
    cyc("fl_run",  0, 1,0,0, 0,0,0,0, 0, 0,0, 0, 1,0,0);
    chk("fl_run.stall_cycles", 32'(bus.stall_cycles), 32'd7);
    chk("fl_run.deadlock", 32'(bus.deadlock), 32'h0);

    // drain with r2 and r9 pending
    cyc("dr_i2",   0, 1,2,1, 0,0,0,0, 0, 0,0, 0, 1,0,0);
    cyc("dr_i9",   0, 1,9,1, 0,0,0,0, 0, 0,0, 0, 1,0,0);
    cyc("dr_req",  0, 0,0,0, 0,0,0,0, 0, 0,0, 1, 0,0,0);
    chk("dr_req.pending", 32'(bus.pending), 32'h0204);
    cyc("dr_hold", 0, 1,0,0, 0,0,0,0, 0, 0,0, 1, 0,1,0);
    cyc("dr_wb2",  0, 0,0,0, 0,0,0,0, 0, 1,2, 1, 0,0,0);
    cyc("dr_wb9",  0, 0,0,0, 0,0,0,0, 0, 1,9, 1, 0,0,1);
    cyc("dr_low",  0, 0,0,0, 0,0,0,0, 0, 0,0, 0, 0,0,1);
    chk("dr_low.pending", 32'(bus.pending), 32'h0);
    cyc("dr_run",  0, 1,0,0, 0,0,0,0, 0, 0,0, 0, 1,0,0);
    chk("dr_run.stall_cycles", 32'(bus.stall_cycles), 32'd8);

    // reset in the middle of a drain
    cyc("rd_iss",  0, 1,10,1, 0,0,0,0, 0, 0,0, 0, 1,0,0);
    cyc("rd_req",  0, 0,0,0, 0,0,0,0, 0, 0,0, 1, 0,0,0);
    cyc("rd_st",   0, 1,0,0, 0,0,0,0, 0, 0,0, 1, 0,1,0);
    chk("rd_st.pending", 32'(bus.pending), 32'h0400);
    cyc("rd_rst",  1, 1,0,0, 0,0,0,0, 0, 0,0, 1, 0,0,0);
    cyc("rd_run",  0, 1,0,0, 0,0,0,0, 0, 0,0, 0, 1,0,0);
    chk("rd_run.pending", 32'(bus.pending), 32'h0);
    chk("rd_run.stall_cycles", 32'(bus.stall_cycles), 32'h0);
    chk("rd_run.deadlock", 32'(bus.deadlock), 32'h0);

    // stall timeout: 64 stall cycles raise the sticky deadlock flag
    cyc("dl_iss",  0, 1,11,1, 0,0,0,0, 0, 0,0, 0, 1,0,0);
    for (int i = 0; i < 64; i++) begin
      cyc("dl_st", 0, 1,0,0, 11,1,0,0, 0, 0,0, 0, 0,1,0);
      if (i == 63) chk("dl_st63.deadlock", 32'(bus.deadlock), 32'h0);
    end
    cyc("dl_wb",   0, 1,0,0, 11,1,0,0, 0, 1,11, 0, 1,0,0);
    chk("dl_wb.deadlock", 32'(bus.deadlock), 32'h1);
    chk("dl_wb.stall_cycles", 32'(bus.stall_cycles), 32'd64);
    cyc("dl_nop",  0, 0,0,0, 0,0,0,0, 0, 0,0, 0, 0,0,0);
    chk("dl_nop.deadlock", 32'(bus.deadlock), 32'h1);
    chk("dl_nop.pending", 32'(bus.pending), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: NREG, 16, number of architectural registers; scalar and vector share the 4-bit index space.
REQ-002 Parameter: TIMEOUT, 64, consecutive stall cycles before the deadlock flag is raised.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 dec_valid  in  1  decode stage holds a valid instruction.
REQ-006 dec_rd  in  4  destination register of the decoded instruction.
REQ-007 dec_wr  in  1  instruction writes dec_rd (RegWriteEnSc OR RegWriteEnVec).
REQ-008 dec_rs1 / dec_rs2  in  4 each  source registers.
REQ-009 dec_rs1_used / dec_rs2_used  in  1 each  the corresponding source is read.
REQ-010 flush  in  1  kill the instruction in decode this cycle.
REQ-011 wb_en  in  1  writeback stage commits a register write this cycle.
REQ-012 wb_rd  in  4  register written back.
REQ-013 drain_req  in  1  request to quiesce; held high until drained is seen.
REQ-014 issue  out  1  decoded instruction advances to execute this cycle.
REQ-015 stall  out  1  decode/fetch must hold their contents.
REQ-016 drained  out  1  DRAIN state and no register pending.
REQ-017 pending  out  NREG  per-register in-flight write bitmap.
REQ-018 deadlock  out  1  sticky stall-timeout flag.
REQ-019 stall_cycles  out  16  saturating count of stall cycles.

Function
REQ-020 Effective pending, eff = pending AND NOT (wb_en ? onehot(wb_rd) : 0); a write committed this cycle is visible to a reader in the same cycle (write-through register file).
REQ-021 hazard = (rs1_used AND eff[rs1]) OR (rs2_used AND eff[rs2]) OR (dec_wr AND eff[rd]); the destination check prevents WAW, so there is at most one in-flight write per register.
REQ-022 FSM states: RUN, STALL, DRAIN.
REQ-023 RUN: issue = dec_valid AND NOT hazard AND NOT flush; stall = dec_valid AND hazard AND NOT flush; next state is STALL if stall is asserted, DRAIN if drain_req is asserted, otherwise RUN.
REQ-024 STALL: issue and stall are computed as in RUN; the FSM returns to RUN when hazard clears or on flush; drain_req is deferred until the FSM returns to RUN.
REQ-025 DRAIN: issue = 0; stall = dec_valid; drained = (eff == 0); the FSM returns to RUN on the cycle after drain_req falls.
REQ-026 Pending update at the clock edge: clear bit wb_rd if wb_en; then set bit dec_rd if issue AND dec_wr. If both target the same register in one cycle, set wins and the bit stays 1.
REQ-027 A wb_en to a register whose pending bit is 0 is ignored (no state change).
REQ-028 Stall counter: a 7-bit counter increments each cycle stall = 1 and clears whenever stall = 0; when it reaches TIMEOUT, deadlock is set and stays set until reset.
REQ-029 stall_cycles increments each cycle stall = 1 and saturates at 0xFFFF with no wrap.
REQ-030 flush has priority over hazard: issue = 0, stall = 0, and no pending bit is set.
REQ-031 Outputs issue, stall and drained are combinational from current state and inputs; pending, deadlock and stall_cycles are registered.

Reset
REQ-032 While reset is high: state = RUN, pending = 0, stall counter = 0, stall_cycles = 0, deadlock = 0; issue = 0 and stall = 0 regardless of inputs.
REQ-033 Reset asserted mid-stall or mid-drain abandons the operation and behaves exactly as REQ-032 on the next edge.

Verification
REQ-034 RAW: issue rd=5 with dec_wr; next cycle rs1=5 used -> stall=1 and issue=0 until wb_en/wb_rd=5; in that wb cycle issue=1; stall_cycles equals the number of stall cycles.
REQ-035 Same-cycle set and clear: pending[3]=1; wb_rd=3 and issue of an instruction writing 3 in the same cycle -> pending[3] stays 1 and issue=1.
REQ-036 WAW: pending[7]=1; instruction with rd=7 and no sources -> stall until wb_rd=7.
REQ-037 Deadlock: hold a hazard with no writeback for 64 cycles -> deadlock=1 on cycle 64 and remains 1 after the hazard clears.
REQ-038 Drain: pending={2,9}; drain_req=1 -> issue=0 and drained=0; wb 2 then wb 9 -> drained=1 in the wb-9 cycle; drain_req=0 -> RUN next cycle.
REQ-039 Flush and reset: flush during STALL -> RUN with pending unchanged; reset mid-DRAIN -> pending=0, state RUN, all counters 0.
